// File: rtl/speedpong_pkg.sv
// Shared SpeedPong types and widths: game state encoding, score/speed/coordinate
// widths and the speed ramp helper.
package speedpong_pkg;

    localparam int SCORE_W = 4;
    localparam int SPEED_W = 3;
    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } game_state_t;

    function automatic logic [SPEED_W-1:0] speed_up(input logic [SPEED_W-1:0] cur,
                                                    input logic [SPEED_W-1:0] max_speed);
        return (cur >= max_speed) ? max_speed : cur + 1'b1;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-tick counter for the serve countdown and the post-point pause.
// load clears the count and latches the target; done fires on the final tick.
module pong_frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] count_nx;

    assign count_nx = count + 1'b1;

    // done is combinational so the controller moves on the edge that samples the Nth tick;
    // ticks during the load cycle are dropped.
    assign done = en && tick && !load && (count_nx == target);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            target <= '0;
        end else if (load) begin
            count  <= '0;
            target <= load_val;
        end else if (en && tick && !done) begin
            count  <= count_nx;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// SpeedPong game sequencer: frame-paced FSM gating paddles and ball, keeping score,
// ramping ball speed with rally length and declaring the winner.
module pong_game_ctrl
    import speedpong_pkg::*;
#(
    parameter int SERVE_FRAMES   = 60,
    parameter int POINT_FRAMES   = 90,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_SPEED      = 7,
    parameter int WIN_SCORE      = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               hit,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               paddle_en,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner,
    output game_state_t        state
);

    localparam int FRAMES_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = $clog2(FRAMES_MAX + 1);
    localparam int HIT_W      = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_CNT = CNT_W'(POINT_FRAMES);
    localparam logic [HIT_W-1:0]   HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

    logic             start_q;
    logic             start_rise;
    logic [HIT_W-1:0] hit_cnt;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_en;
    logic             timer_done;
    logic [SCORE_W-1:0] score_l_inc;
    logic [SCORE_W-1:0] score_r_inc;

    assign start_rise  = start && !start_q;
    assign timer_en    = (state == SERVE) || (state == POINT);
    assign score_l_inc = score_l + 1'b1;
    assign score_r_inc = score_r + 1'b1;

    pong_frame_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .tick     (frame_tick),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            paddle_en  <= 1'b0;
            ball_run   <= 1'b0;
            ball_reset <= 1'b0;
            serve_dir  <= 1'b0;
            speed      <= SPEED_W'(1);
            score_l    <= '0;
            score_r    <= '0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            hit_cnt    <= '0;
            timer_load <= 1'b0;
            timer_val  <= '0;
            // Loaded high so a button held through reset is not seen as a press.
            start_q    <= 1'b1;
        end else begin
            start_q    <= start;
            ball_reset <= 1'b0;
            timer_load <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        state      <= SERVE;
                        score_l    <= '0;
                        score_r    <= '0;
                        speed      <= SPEED_W'(1);
                        hit_cnt    <= '0;
                        game_over  <= 1'b0;
                        winner     <= 1'b0;
                        paddle_en  <= 1'b1;
                        ball_run   <= 1'b0;
                        ball_reset <= 1'b1;
                        timer_load <= 1'b1;
                        timer_val  <= SERVE_CNT;
                    end
                end
                SERVE: begin
                    if (timer_done) begin
                        state    <= PLAY;
                        ball_run <= 1'b1;
                    end
                end
                PLAY: begin
                    // miss_l outranks miss_r, and any miss outranks a hit.
                    if (miss_l) begin
                        score_r   <= score_r_inc;
                        serve_dir <= 1'b0;
                        paddle_en <= 1'b0;
                        ball_run  <= 1'b0;
                        if (score_r_inc == SCORE_WIN) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else begin
                            state      <= POINT;
                            timer_load <= 1'b1;
                            timer_val  <= POINT_CNT;
                        end
                    end else if (miss_r) begin
                        score_l   <= score_l_inc;
                        serve_dir <= 1'b1;
                        paddle_en <= 1'b0;
                        ball_run  <= 1'b0;
                        if (score_l_inc == SCORE_WIN) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end else begin
                            state      <= POINT;
                            timer_load <= 1'b1;
                            timer_val  <= POINT_CNT;
                        end
                    end else if (hit) begin
                        if (hit_cnt == HIT_LAST) begin
                            hit_cnt <= '0;
                            speed   <= speed_up(speed, SPEED_MAX);
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end
                end
                POINT: begin
                    if (timer_done) begin
                        state      <= SERVE;
                        speed      <= SPEED_W'(1);
                        hit_cnt    <= '0;
                        paddle_en  <= 1'b1;
                        ball_reset <= 1'b1;
                        timer_load <= 1'b1;
                        timer_val  <= SERVE_CNT;
                    end
                end
                default: begin
                    state     <= IDLE;
                    paddle_en <= 1'b0;
                    ball_run  <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a directed table of one-cycle vectors with expected
// outputs, then randomized play checked against a rule-level game model.
module tb_pong_game_ctrl;
    import speedpong_pkg::*;

    localparam int SF  = 2;
    localparam int PF  = 3;
    localparam int HPL = 2;
    localparam int MAXS = 3;
    localparam int WIN = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_tick = 1'b0, start = 1'b0, hit = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
    logic paddle_en, ball_run, ball_reset, serve_dir, game_over, winner;
    logic [2:0] speed;
    logic [3:0] score_l, score_r;
    game_state_t state;

    pong_game_ctrl #(
        .SERVE_FRAMES   (SF),
        .POINT_FRAMES   (PF),
        .HITS_PER_LEVEL (HPL),
        .MAX_SPEED      (MAXS),
        .WIN_SCORE      (WIN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .hit        (hit),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .paddle_en  (paddle_en),
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .speed      (speed),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pe, br, rs, dir;
        logic [2:0] spd;
        logic [3:0] sl, sr;
        logic       go, win;
    } outs_t;

    typedef struct packed {
        logic  rst_n, st, tk, ht, ml, mr;
        outs_t exp;
    } vec_t;

    vec_t tbl[$];
    int vectors = 0;
    int miscompares = 0;

    // Rule-level game model.
    game_state_t m_mode;
    int  m_frames, m_hits, m_sl, m_sr;
    bit  m_first, m_dir, m_over, m_win, m_start_prev;

    function automatic outs_t mk(game_state_t s, bit pe, bit br, bit rs, bit dir,
                                 int spd, int sl, int sr, bit go, bit win);
        outs_t o;
        o.st = s; o.pe = pe; o.br = br; o.rs = rs; o.dir = dir;
        o.spd = 3'(spd); o.sl = 4'(sl); o.sr = 4'(sr); o.go = go; o.win = win;
        return o;
    endfunction

    function automatic void add(bit r, bit s, bit t, bit h, bit l, bit m, outs_t e);
        vec_t v;
        v.rst_n = r; v.st = s; v.tk = t; v.ht = h; v.ml = l; v.mr = m; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        int spd;
        spd = 1 + m_hits / HPL;
        if (spd > MAXS) spd = MAXS;
        o = mk(m_mode, (m_mode == SERVE) || (m_mode == PLAY), m_mode == PLAY,
               m_first && (m_mode == SERVE), m_dir, spd, m_sl, m_sr, m_over, m_win);
        return o;
    endfunction

    task automatic model_step(bit r, bit s, bit t, bit h, bit l, bit m);
        bit rise, entered;
        if (!r) begin
            m_mode = IDLE; m_frames = 0; m_hits = 0; m_sl = 0; m_sr = 0;
            m_first = 0; m_dir = 0; m_over = 0; m_win = 0; m_start_prev = 1;
            return;
        end
        rise = s && !m_start_prev;
        m_start_prev = s;
        entered = 0;
        case (m_mode)
            IDLE, OVER: if (rise) begin
                m_sl = 0; m_sr = 0; m_hits = 0; m_over = 0; m_win = 0;
                m_mode = SERVE; entered = 1;
            end
            SERVE, POINT: if (!m_first && t) begin
                m_frames++;
                if (m_mode == SERVE && m_frames == SF) begin
                    m_mode = PLAY; entered = 1;
                end else if (m_mode == POINT && m_frames == PF) begin
                    m_mode = SERVE; m_hits = 0; entered = 1;
                end
            end
            PLAY: if (l) begin
                m_sr++; m_dir = 0;
                if (m_sr == WIN) begin m_mode = OVER; m_over = 1; m_win = 1; end
                else m_mode = POINT;
                entered = 1;
            end else if (m) begin
                m_sl++; m_dir = 1;
                if (m_sl == WIN) begin m_mode = OVER; m_over = 1; m_win = 0; end
                else m_mode = POINT;
                entered = 1;
            end else if (h) begin
                m_hits++;
            end
            default: ;
        endcase
        m_first = entered;
        if (entered) m_frames = 0;
    endtask

    function automatic outs_t actual();
        return mk(state, paddle_en, ball_run, ball_reset, serve_dir, int'(speed),
                  int'(score_l), int'(score_r), game_over, winner);
    endfunction

    task automatic check(string name, outs_t exp);
        outs_t act;
        act = actual();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got st=%0d pe=%0b br=%0b rs=%0b dir=%0b spd=%0d sl=%0d sr=%0d go=%0b win=%0b, want st=%0d pe=%0b br=%0b rs=%0b dir=%0b spd=%0d sl=%0d sr=%0d go=%0b win=%0b",
                     name, act.st, act.pe, act.br, act.rs, act.dir, act.spd, act.sl, act.sr, act.go, act.win,
                     exp.st, exp.pe, exp.br, exp.rs, exp.dir, exp.spd, exp.sl, exp.sr, exp.go, exp.win);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are read at the next falling edge.
    task automatic drive(bit r, bit s, bit t, bit h, bit l, bit m);
        reset = r; start = s; frame_tick = t; hit = h; miss_l = l; miss_r = m;
        @(posedge clk);
        model_step(r, s, t, h, l, m);
        @(negedge clk);
    endtask

    initial begin
        // reset/start held, release, press
        add(0,1,0,0,0,0, mk(IDLE, 0,0,0,0,1,0,0,0,0));
        add(0,1,0,0,0,0, mk(IDLE, 0,0,0,0,1,0,0,0,0));
        add(1,1,0,0,0,0, mk(IDLE, 0,0,0,0,1,0,0,0,0));
        add(1,1,0,0,0,0, mk(IDLE, 0,0,0,0,1,0,0,0,0));
        add(1,0,0,0,0,0, mk(IDLE, 0,0,0,0,1,0,0,0,0));
        add(1,1,0,0,0,0, mk(SERVE,1,0,1,0,1,0,0,0,0));
        add(1,1,1,0,0,0, mk(SERVE,1,0,0,0,1,0,0,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,0,1,0,0,0,0));
        add(1,0,0,0,0,0, mk(SERVE,1,0,0,0,1,0,0,0,0));
        add(1,0,1,0,0,0, mk(PLAY, 1,1,0,0,1,0,0,0,0));
        add(1,0,1,0,0,0, mk(PLAY, 1,1,0,0,1,0,0,0,0));
        // speed ramp with saturation
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,0,1,0,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,0,2,0,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,0,2,0,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,0,3,0,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,0,3,0,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,0,3,0,0,0,0));
        // miss_l with hit, then point pause
        add(1,0,0,1,1,0, mk(POINT,0,0,0,0,3,0,1,0,0));
        add(1,0,1,0,0,0, mk(POINT,0,0,0,0,3,0,1,0,0));
        add(1,0,1,0,0,0, mk(POINT,0,0,0,0,3,0,1,0,0));
        add(1,0,1,0,0,0, mk(POINT,0,0,0,0,3,0,1,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,1,0,1,0,1,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,0,1,0,1,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,0,1,0,1,0,0));
        add(1,0,1,0,0,0, mk(PLAY, 1,1,0,0,1,0,1,0,0));
        // two miss_r rallies to game over
        add(1,0,0,0,0,1, mk(POINT,0,0,0,1,1,1,1,0,0));
        add(1,0,0,0,0,0, mk(POINT,0,0,0,1,1,1,1,0,0));
        add(1,0,1,0,0,0, mk(POINT,0,0,0,1,1,1,1,0,0));
        add(1,0,1,0,0,0, mk(POINT,0,0,0,1,1,1,1,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,1,1,1,1,1,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,1,1,1,1,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,1,1,1,1,0,0));
        add(1,0,1,0,0,0, mk(PLAY, 1,1,0,1,1,1,1,0,0));
        add(1,0,0,0,0,1, mk(OVER, 0,0,0,1,1,2,1,1,0));
        add(1,0,0,0,1,0, mk(OVER, 0,0,0,1,1,2,1,1,0));
        add(1,0,0,1,0,1, mk(OVER, 0,0,0,1,1,2,1,1,0));
        add(1,1,0,0,0,0, mk(SERVE,1,0,1,1,1,0,0,0,0));
        // new game up to speed 2, score_l 1, then mid-play reset
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,1,1,0,0,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,1,1,0,0,0,0));
        add(1,0,1,0,0,0, mk(PLAY, 1,1,0,1,1,0,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,1,1,0,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,1,2,0,0,0,0));
        add(1,0,0,0,0,1, mk(POINT,0,0,0,1,2,1,0,0,0));
        add(1,0,1,0,0,0, mk(POINT,0,0,0,1,2,1,0,0,0));
        add(1,0,1,0,0,0, mk(POINT,0,0,0,1,2,1,0,0,0));
        add(1,0,1,0,0,0, mk(POINT,0,0,0,1,2,1,0,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,1,1,1,1,0,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,1,1,1,0,0,0));
        add(1,0,1,0,0,0, mk(SERVE,1,0,0,1,1,1,0,0,0));
        add(1,0,1,0,0,0, mk(PLAY, 1,1,0,1,1,1,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,1,1,1,0,0,0));
        add(1,0,0,1,0,0, mk(PLAY, 1,1,0,1,2,1,0,0,0));
        add(0,1,0,0,0,0, mk(IDLE, 0,0,0,0,1,0,0,0,0));
        add(1,1,0,0,0,0, mk(IDLE, 0,0,0,0,1,0,0,0,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].st, tbl[i].tk, tbl[i].ht, tbl[i].ml, tbl[i].mr);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Randomized play against the model.
        drive(0, 0, 0, 0, 0, 0);
        check("rand_reset", model_outs());
        begin
            bit s;
            s = 0;
            for (int n = 0; n < 4000; n++) begin
                bit r;
                if ($urandom_range(0, 7) == 0) s = ~s;
                r = ($urandom_range(0, 499) != 0);
                drive(r, s, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
                check($sformatf("rand%0d", n), model_outs());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for SpeedPong: a frame-paced state machine that gates the paddle datapath (`paddle_en`) and ball datapath (`ball_run`, `ball_reset`, `serve_dir`). It keeps score, ramps ball speed with rally length, and declares a winner. It sits between the paddle/ball modules and the VGA frame timing, consuming per-frame ticks and collision pulses from the ball logic.

## Interface
Parameters:
- SERVE_FRAMES, 60: frames of countdown before the ball is released.
- POINT_FRAMES, 90: frames of pause after a point.
- HITS_PER_LEVEL, 4: paddle hits per speed increment.
- MAX_SPEED, 7: speed saturation value (≤7).
- WIN_SCORE, 7: score that ends the game (≤15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; one clock domain.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  start button level, already synchronised.
- hit  in  1  one-cycle pulse: ball struck either paddle.
- miss_l  in  1  one-cycle pulse: ball passed left edge, so the right player scores.
- miss_r  in  1  one-cycle pulse: ball passed right edge, so the left player scores.
- paddle_en  out  1  paddles may move.
- ball_run  out  1  ball advances.
- ball_reset  out  1  one-cycle pulse: recentre ball.
- serve_dir  out  1  0 = serve toward left, 1 = toward right.
- speed  out  3  current ball speed level, 1..MAX_SPEED.
- score_l, score_r  out  4  player scores.
- game_over  out  1  game finished.
- winner  out  1  0 = left, 1 = right; valid while game_over.

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER.
- Per-state outputs (paddle_en/ball_run/game_over):
  - IDLE 0/0/0
  - SERVE 1/0/0
  - PLAY 1/1/0
  - POINT 0/0/0
  - OVER 0/0/1
- start_rise = start high this cycle and low the previous cycle (internal edge register).
- IDLE → SERVE on start_rise. Clear both scores, set speed = 1, clear the hit counter.
- SERVE → PLAY after SERVE_FRAMES frame_ticks have been counted in SERVE.
- In PLAY:
  - hit increments the hit counter.
  - When the counter reaches HITS_PER_LEVEL, it returns to 0 and speed increments, saturating at MAX_SPEED.
- miss_l in PLAY: score_r += 1; serve_dir = 0.
- miss_r in PLAY: score_l += 1; serve_dir = 1.
- After a miss, go to OVER if the new score equals WIN_SCORE, otherwise to POINT.
- POINT → SERVE after POINT_FRAMES ticks. On that transition, set speed = 1 and clear the hit counter.
- OVER: winner = the player who reached WIN_SCORE. On start_rise, go to SERVE with the same clearing as IDLE.
- Simultaneous events in PLAY:
  - miss_l and miss_r together: miss_l wins; miss_r is ignored.
  - Any miss with hit: the miss wins; hit is ignored.
- hit, miss_l and miss_r are ignored outside PLAY. start is ignored outside IDLE and OVER.
- Scores never exceed WIN_SCORE.

## Timing
- All outputs are registered. The state change and its outputs appear on the clock edge after the causing input is sampled.
- ball_reset is high for exactly one cycle: the first cycle in SERVE, on every entry.
- Frame counter:
  - Cleared on the cycle a state is entered.
  - Counts frame_tick only while in SERVE or POINT.
  - The transition happens on the edge after the Nth tick.
  - A tick on the transition cycle itself is not counted.
- Reset (reset low at a rising edge), including mid-game:
  - state = IDLE; paddle_en = ball_run = ball_reset = 0.
  - serve_dir = 0; speed = 1; score_l = score_r = 0.
  - game_over = winner = 0; counters = 0.
  - The start edge register is loaded with 1, so a held button does not start a game out of reset.

## Structure
- Shared package `speedpong_pkg`: state enum `game_state_t`, and constants SCORE_W = 4, SPEED_W = 3, COORD_W = 10.
- One sub-module, `pong_frame_timer`: frame-tick counter with load and clear, and a `done` output at the programmed count. It is instantiated once and reloaded with SERVE_FRAMES or POINT_FRAMES on state entry.

## Test plan
Bench overrides: SERVE_FRAMES = 2, POINT_FRAMES = 3, HITS_PER_LEVEL = 2, MAX_SPEED = 3, WIN_SCORE = 2.
- Reset with start held high, then release reset → stays IDLE, all outputs at reset values. start low then high → SERVE next edge, ball_reset high 1 cycle, paddle_en = 1, ball_run = 0.
- Two frame_ticks in SERVE → ball_run = 1 on the edge after the second tick. A tick on the entry cycle is not counted.
- Six hit pulses in PLAY → speed 1 → 2 after the 2nd hit, 3 after the 4th, stays 3 after the 6th.
- miss_l and hit in the same cycle → score_r = 1, score_l = 0, serve_dir = 0, state POINT, speed unchanged. After 3 ticks → SERVE, speed = 1, ball_reset pulses.
- Two miss_r pulses in separate rallies → score_l = 2, game_over = 1, winner = 0. Further miss/hit pulses leave the scores unchanged. start rise → SERVE, scores 0.
- Assert reset mid-PLAY with score_l = 1 and speed = 2 → next edge all outputs at reset values, state IDLE.
